// File: rtl/ex_alu_stage.sv
// Execute stage of the MIPS pipeline: operand forwarding, ALU, and the
// EX/MEM pipeline register with stall, flush and bubble handling.
module ex_alu_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [2:0]       alu_ctrl,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [REGW-1:0]  rd_in,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             mem_to_reg_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] store_data,
  output logic [REGW-1:0]  rd_out,
  output logic             reg_write_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic             mem_to_reg_out
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] fwdb;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] result;
  logic             ovf_next;

  // Forwarding muxes; source 10 is the registered result, so it naturally
  // keeps selecting the held value while the EX/MEM register is stalled.
  always_comb begin
    opa  = rs_data;
    fwdb = rt_data;
    case (fwd_a)
      2'b01:   opa = wb_data;
      2'b10:   opa = alu_result;
      default: opa = rs_data;
    endcase
    case (fwd_b)
      2'b01:   fwdb = wb_data;
      2'b10:   fwdb = alu_result;
      default: fwdb = rt_data;
    endcase
    opb = alu_src ? imm_ext : fwdb;
  end

  // ALU datapath and signed-overflow detection (flag only, never traps).
  always_comb begin
    sum      = opa + opb;
    diff     = opa - opb;
    result   = '0;
    ovf_next = 1'b0;
    case (alu_ctrl)
      OP_AND: result = opa & opb;
      OP_OR:  result = opa | opb;
      OP_ADD: begin
        result   = sum;
        ovf_next = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        result   = diff;
        ovf_next = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      default: begin
        result   = '0;
        ovf_next = 1'b0;
      end
    endcase
  end

  // EX/MEM register: reset beats flush beats stall; bubbles still load data
  // but clear valid and every control bit so nothing downstream acts on them.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      zero           <= 1'b0;
      ovf            <= 1'b0;
      store_data     <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
    end else if (!stall) begin
      out_valid      <= in_valid;
      alu_result     <= result;
      zero           <= (result == '0);
      ovf            <= ovf_next;
      store_data     <= fwdb;
      rd_out         <= rd_in;
      reg_write_out  <= in_valid & reg_write_in;
      mem_read_out   <= in_valid & mem_read_in;
      mem_write_out  <= in_valid & mem_write_in;
      mem_to_reg_out <= in_valid & mem_to_reg_in;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage with hand-computed vectors.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, alu_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] rs_data, rt_data, imm_ext, wb_data;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        out_valid, zero, ovf;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;

  int numCompared   = 0;
  int numMismatched = 0;

  ex_alu_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .rs_data(rs_data), .rt_data(rt_data),
    .imm_ext(imm_ext), .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .out_valid(out_valid), .alu_result(alu_result), .zero(zero), .ovf(ovf),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_to_reg_out(mem_to_reg_out)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just after it before sampling.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = ctrl;
    rs_data  = a;
    rt_data  = b;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, ".result"}, alu_result, 32'd0);
    checkOutput({tag, ".zero"}, {31'b0, zero}, 32'd0);
    checkOutput({tag, ".ovf"}, {31'b0, ovf}, 32'd0);
    checkOutput({tag, ".store"}, store_data, 32'd0);
    checkOutput({tag, ".rd"}, {27'b0, rd_out}, 32'd0);
    checkOutput({tag, ".ctrls"},
                {28'b0, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}, 32'd0);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; in_valid = 0; alu_src = 0; alu_ctrl = 3'b000;
    rs_data = 0; rt_data = 0; imm_ext = 0; wb_data = 0; fwd_a = 0; fwd_b = 0;
    rd_in = 0; reg_write_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;

    // Reset then idle
    applyStimulus();
    applyStimulus();
    checkAllZero("reset");
    rst = 0;
    applyStimulus();
    checkOutput("idle.valid", {31'b0, out_valid}, 32'd0);

    // add overflow
    in_valid = 1; rd_in = 5'd5; reg_write_in = 1; mem_read_in = 1;
    setOp(3'b010, 32'h7FFF_FFFF, 32'h1);
    applyStimulus();
    checkOutput("addovf.result", alu_result, 32'h8000_0000);
    checkOutput("addovf.ovf", {31'b0, ovf}, 32'd1);
    checkOutput("addovf.zero", {31'b0, zero}, 32'd0);
    checkOutput("addovf.valid", {31'b0, out_valid}, 32'd1);
    checkOutput("addovf.rd", {27'b0, rd_out}, 32'd5);
    checkOutput("addovf.ctrls",
                {28'b0, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}, 32'hC);
    checkOutput("addovf.store", store_data, 32'h1);
    reg_write_in = 0; mem_read_in = 0;

    // sub to zero
    setOp(3'b011, 32'd5, 32'd5);
    applyStimulus();
    checkOutput("sub0.result", alu_result, 32'd0);
    checkOutput("sub0.zero", {31'b0, zero}, 32'd1);
    checkOutput("sub0.ovf", {31'b0, ovf}, 32'd0);

    // sub overflow
    setOp(3'b011, 32'h8000_0000, 32'h1);
    applyStimulus();
    checkOutput("subovf.result", alu_result, 32'h7FFF_FFFF);
    checkOutput("subovf.ovf", {31'b0, ovf}, 32'd1);

    // slt signed, both orders
    setOp(3'b111, 32'hFFFF_FFFF, 32'h1);
    applyStimulus();
    checkOutput("slt.lt", alu_result, 32'd1);
    checkOutput("slt.lt.zero", {31'b0, zero}, 32'd0);
    setOp(3'b111, 32'h1, 32'hFFFF_FFFF);
    applyStimulus();
    checkOutput("slt.ge", alu_result, 32'd0);
    checkOutput("slt.ge.zero", {31'b0, zero}, 32'd1);

    // and / or / unknown code
    setOp(3'b000, 32'h0000_F0F0, 32'h0000_FF00);
    applyStimulus();
    checkOutput("and", alu_result, 32'h0000_F000);
    setOp(3'b001, 32'h0000_F0F0, 32'h0000_FF00);
    applyStimulus();
    checkOutput("or", alu_result, 32'h0000_FFF0);
    setOp(3'b100, 32'h7FFF_FFFF, 32'h1);
    applyStimulus();
    checkOutput("unk.result", alu_result, 32'd0);
    checkOutput("unk.ovf", {31'b0, ovf}, 32'd0);
    checkOutput("unk.zero", {31'b0, zero}, 32'd1);

    // Back-to-back forwarding
    setOp(3'b010, 32'd3, 32'd4);
    applyStimulus();
    checkOutput("fwd.base", alu_result, 32'd7);
    setOp(3'b010, 32'h55, 32'h66);
    fwd_a = 2'b10; imm_ext = 32'd10; alu_src = 1;
    applyStimulus();
    checkOutput("fwd.own", alu_result, 32'd17);
    setOp(3'b001, 32'h55, 32'h66);
    alu_src = 0; fwd_b = 2'b01; wb_data = 32'h100;
    applyStimulus();
    checkOutput("fwd.wb", alu_result, 32'h111);
    checkOutput("fwd.wb.store", store_data, 32'h100);
    setOp(3'b010, 32'h20, 32'h2);
    fwd_a = 2'b11; fwd_b = 2'b11;
    applyStimulus();
    checkOutput("fwd.11", alu_result, 32'h22);
    fwd_a = 0; fwd_b = 0;

    // Stall holds for three cycles despite changing inputs
    setOp(3'b010, 32'h10, 32'h20);
    rd_in = 5'd9; reg_write_in = 1; mem_to_reg_in = 1;
    applyStimulus();
    checkOutput("preStall.result", alu_result, 32'h30);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      setOp(3'b011, 32'h100 + i, 32'h7);
      rd_in = 5'(i + 1); reg_write_in = 0; in_valid = i[0];
      applyStimulus();
      checkOutput($sformatf("stall%0d.result", i), alu_result, 32'h30);
      checkOutput($sformatf("stall%0d.valid", i), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("stall%0d.rd", i), {27'b0, rd_out}, 32'd9);
      checkOutput($sformatf("stall%0d.ctrls", i),
                  {28'b0, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}, 32'h9);
    end
    // Own-result forwarding after the stall still sees the held 0x30
    stall = 0; in_valid = 1; fwd_a = 2'b10;
    setOp(3'b010, 32'hDEAD, 32'h1);
    applyStimulus();
    checkOutput("postStall.fwd", alu_result, 32'h31);
    fwd_a = 0;

    // Flush overrides stall
    stall = 1; flush = 1;
    applyStimulus();
    checkAllZero("flush");
    stall = 0; flush = 0;

    // Reset mid-stall
    setOp(3'b010, 32'h40, 32'h2);
    applyStimulus();
    checkOutput("preRst.result", alu_result, 32'h42);
    stall = 1;
    applyStimulus();
    rst = 1;
    applyStimulus();
    checkAllZero("rstStall");
    rst = 0; stall = 0;

    // Bubble gates controls but loads data
    in_valid = 0; reg_write_in = 1; mem_write_in = 1; mem_to_reg_in = 0;
    setOp(3'b010, 32'h1, 32'h2);
    applyStimulus();
    checkOutput("bubble.ctrls",
                {28'b0, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}, 32'h0);
    checkOutput("bubble.valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bubble.result", alu_result, 32'h3);

    // Store: address from immediate, data from forwarded rt
    in_valid = 1; reg_write_in = 0; mem_write_in = 1;
    setOp(3'b010, 32'h1000, 32'hAB);
    imm_ext = 32'h8; alu_src = 1; fwd_b = 2'b00;
    applyStimulus();
    checkOutput("store.data", store_data, 32'hAB);
    checkOutput("store.addr", alu_result, 32'h1008);
    checkOutput("store.ctrls",
                {28'b0, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
